// File: rtl/myproject_dense_pkg.sv
// ---------------------------------------------------------------------------
// myproject_dense_pkg
//   Shared definitions for the dense-layer accumulate/requantise blocks of the
//   mini autoencoder.
//   - clog2()        : constant-evaluable ceiling log2, used for widths
//   - *_DEF          : default widths/shift for the 16s x 9ns product path
//   - state_t        : accumulator FSM states (ACC, SUM)
//   - SAT_*_DEF      : saturation limits of the default output format
//   - dense_dbg_t    : compact view of the accumulator control state
// ---------------------------------------------------------------------------
package myproject_dense_pkg;

  // Ceiling log2; clog2(1) = 0, clog2(8) = 3, clog2(9) = 4.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  localparam int PROD_W_DEF = 25;
  localparam int OUT_W_DEF  = 16;
  localparam int SHIFT_DEF  = 8;

  localparam int SAT_MAX_DEF = (2 ** (OUT_W_DEF - 1)) - 1;
  localparam int SAT_MIN_DEF = -(2 ** (OUT_W_DEF - 1));

  typedef enum logic {
    ACC = 1'b0,  // collecting products of the current neuron
    SUM = 1'b1   // sum complete, waiting to move it into the output slot
  } state_t;

  // Control snapshot of one accumulator instance.
  typedef struct packed {
    state_t state;
    logic   out_vld;
    logic   ce;
  } dense_dbg_t;

endpackage

// File: rtl/myproject_requant_sat.sv
// ---------------------------------------------------------------------------
// myproject_requant_sat
//   Combinational requantiser shared by the dense layers:
//     r = (acc + 2^(SHIFT-1)) >>> SHIFT   (round half up, ACC_W+1 bits)
//     optional ReLU (RELU=1 clamps negative r to 0)
//     saturate to the signed OUT_W range
//   Ports:
//     acc  in  ACC_W  signed accumulator value
//     q    out OUT_W  signed requantised result
// ---------------------------------------------------------------------------
module myproject_requant_sat #(
  parameter int ACC_W = 29,
  parameter int SHIFT = 8,
  parameter int OUT_W = 16,
  parameter int RELU  = 1
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] q
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int RW = ACC_W + 1;

  localparam logic signed [RW-1:0] HALF  = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [RW-1:0] MAX_V = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_V = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  generate
    if (SHIFT < 1) begin : g_bad_shift
      $error("myproject_requant_sat: SHIFT must be >= 1");
    end
    if (RW < OUT_W) begin : g_bad_width
      $error("myproject_requant_sat: ACC_W+1 must be >= OUT_W");
    end
  endgenerate

  logic signed [RW-1:0] acc_ext;
  logic signed [RW-1:0] rounded;
  logic signed [RW-1:0] shifted;
  logic signed [RW-1:0] relu_v;

  always_comb begin
    acc_ext = {acc[ACC_W-1], acc};
    rounded = acc_ext + HALF;
    shifted = rounded >>> SHIFT;

    relu_v = shifted;
    if ((RELU != 0) && shifted[RW-1]) begin
      relu_v = '0;
    end

    if (relu_v > MAX_V) begin
      q = MAX_V[OUT_W-1:0];
    end else if (relu_v < MIN_V) begin
      q = MIN_V[OUT_W-1:0];
    end else begin
      q = relu_v[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/myproject_dense_acc_requant.sv
// ---------------------------------------------------------------------------
// myproject_dense_acc_requant
//   Accumulates N_IN signed products for one output neuron, starting from an
//   aligned bias, then requantises (round, shift, ReLU, saturate) and hands
//   the result to the next layer through a one-entry output slot.
//
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   synchronous active-high reset
//     ce         in   clock enable; 0 freezes every register
//     in_prod    in   PROD_W signed product
//     in_valid   in   product present
//     in_ready   out  product accepted when in_valid && in_ready
//     bias       in   BIAS_W signed bias, sampled with the first product
//     out_data   out  OUT_W signed requantised result
//     out_valid  out  result present
//     out_ready  in   consumer accepts the result
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high (and ce is high). valid never depends on ready of the same
//   interface; once out_valid is high the result is held stable until taken.
//
//   Flow: ACC collects N_IN products (one per cycle), then one SUM cycle moves
//   requant(acc) into the output slot. A held output only stalls the SUM->slot
//   transfer, so the next neuron can be accumulated behind it.
// ---------------------------------------------------------------------------
module myproject_dense_acc_requant
  import myproject_dense_pkg::*;
#(
  parameter int PROD_W     = PROD_W_DEF,
  parameter int N_IN       = 8,
  parameter int ACC_W      = PROD_W + clog2(N_IN) + 1,
  parameter int BIAS_W     = 16,
  parameter int BIAS_SHIFT = 8,
  parameter int SHIFT      = SHIFT_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int RELU       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BIAS_W-1:0] bias,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = clog2(N_IN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  generate
    if (N_IN < 2) begin : g_bad_n_in
      $error("myproject_dense_acc_requant: N_IN must be >= 2");
    end
    if (ACC_W < PROD_W || ACC_W < BIAS_W + BIAS_SHIFT) begin : g_bad_acc_w
      $error("myproject_dense_acc_requant: ACC_W too narrow");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                   state_q;
  state_t                   state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     out_vld_q;
  logic [OUT_W-1:0]         out_data_q;

  // Control strobes from the output process
  logic accept;   // product transfer this cycle
  logic last;     // accepted product would be the last one of the neuron
  logic load;     // SUM result moves into the output slot
  logic pop;      // consumer takes the slot contents

  // Datapath
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_al;
  logic signed [ACC_W-1:0] acc_base;
  logic [OUT_W-1:0]        rq_data;

  // Control snapshot, convenient for probes and assertions bound to this block
  dense_dbg_t dbg;
  assign dbg = '{state: state_q, out_vld: out_vld_q, ce: ce};

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACC;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (accept && last) state_d = SUM;
      SUM:     if (load)           state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs and strobes (everything is gated by ce)
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = ce && (state_q == ACC);
    out_valid = ce && out_vld_q;
    accept    = in_valid && in_ready;
    last      = (cnt_q == CNT_LAST);
    pop       = out_valid && out_ready;
    // The slot is free if empty or being emptied on this same edge.
    load      = ce && (state_q == SUM) && (!out_vld_q || out_ready);
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_comb begin
    prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
    bias_al  = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias} <<< BIAS_SHIFT;
    // First product of a neuron starts from the aligned bias, discarding the
    // previous neuron's sum.
    acc_base = (cnt_q == '0) ? bias_al : acc_q;
  end

  myproject_requant_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W),
    .RELU  (RELU)
  ) u_requant (
    .acc (acc_q),
    .q   (rq_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else if (ce) begin
      if (accept) begin
        acc_q <= acc_base + prod_ext;
        cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
      end
      // A load in the same cycle as a pop keeps the slot full with new data.
      if (load) begin
        out_data_q <= rq_data;
        out_vld_q  <= 1'b1;
      end else if (pop) begin
        out_vld_q  <= 1'b0;
      end
    end
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_myproject_dense_acc_requant.sv
// ---------------------------------------------------------------------------
// tb_myproject_dense_acc_requant
//   Two instances share all stimulus: dut0 with RELU=0, dut1 with RELU=1.
//   Each has its own expected queue filled from a behavioural model when the
//   last product of a neuron is accepted and drained by an output monitor.
// ---------------------------------------------------------------------------
module tb_myproject_dense_acc_requant;

  localparam int PROD_W = 25;
  localparam int N_IN   = 8;
  localparam int BIAS_W = 16;
  localparam int OUT_W  = 16;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  logic ce;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // -------------------------------------------------------------------------
  // DUTs
  // -------------------------------------------------------------------------
  logic [PROD_W-1:0] in_prod;
  logic [BIAS_W-1:0] bias;
  logic              in_valid;
  logic              out_ready;
  logic              in_ready0, in_ready1;
  logic              out_valid0, out_valid1;
  logic [OUT_W-1:0]  out_data0, out_data1;

  myproject_dense_acc_requant #(.N_IN(N_IN), .RELU(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_prod   (in_prod),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .bias      (bias),
    .out_data  (out_data0),
    .out_valid (out_valid0),
    .out_ready (out_ready)
  );

  myproject_dense_acc_requant #(.N_IN(N_IN), .RELU(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_prod   (in_prod),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .bias      (bias),
    .out_data  (out_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready)
  );

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Independent model: sum already includes bias*256; round half up, >>>8.
  function automatic logic [OUT_W-1:0] model(input longint sum, input bit relu);
    longint r;
    r = (sum + 128) >>> 8;
    if (relu && r < 0) r = 0;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[OUT_W-1:0];
  endfunction

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [OUT_W-1:0] exp_q0[$];
  logic [OUT_W-1:0] exp_q1[$];

  always @(negedge clk) begin
    if (out_valid0 && out_ready) begin
      if (exp_q0.size() == 0) check_eq("dut0_spurious_out", {31'b0, out_valid0}, 32'd0);
      else check_eq("dut0_data", {16'b0, out_data0}, {16'b0, exp_q0.pop_front()});
    end
    if (out_valid1 && out_ready) begin
      if (exp_q1.size() == 0) check_eq("dut1_spurious_out", {31'b0, out_valid1}, 32'd0);
      else check_eq("dut1_data", {16'b0, out_data1}, {16'b0, exp_q1.pop_front()});
    end
  end

  // -------------------------------------------------------------------------
  // Drivers (inputs change 1 time unit after the rising edge)
  // -------------------------------------------------------------------------
  int prod_buf[N_IN];

  // Sends the first n_prod products of prod_buf. bias is b_first on the first
  // product and b_rest on the others. ce drops for 3 cycles before product
  // gap_at (-1 = never). Expectations are pushed only for complete neurons.
  task automatic send_neuron(input logic [BIAS_W-1:0] b_first, input logic [BIAS_W-1:0] b_rest,
                             input int n_prod, input int gap_at, input bit rand_ready,
                             output int dur);
    longint sum;
    int     t0;
    int     waited;
    bit     ok;
    t0  = cyc;
    sum = longint'($signed(b_first)) * 256;
    for (int i = 0; i < n_prod; i++) begin
      in_valid = 1'b1;
      in_prod  = PROD_W'(prod_buf[i]);
      bias     = (i == 0) ? b_first : b_rest;
      if (i == gap_at) begin
        ce = 1'b0;
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          check_eq("ce_low_in_ready", {31'b0, in_ready0}, 32'd0);
          @(posedge clk); #1;
        end
        ce = 1'b1;
      end
      waited = 0;
      ok     = 1'b0;
      do begin
        @(negedge clk);
        ok = in_ready0;
        @(posedge clk); #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        waited++;
      end while (!ok && waited < 200);
      check_eq("accept", {31'b0, ok}, 32'd1);
      sum += longint'(prod_buf[i]);
    end
    in_valid = 1'b0;
    bias     = BIAS_W'($urandom);
    if (n_prod == N_IN) begin
      exp_q0.push_back(model(sum, 1'b0));
      exp_q1.push_back(model(sum, 1'b1));
    end
    dur = cyc - t0;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < N_IN; i++) prod_buf[i] = v;
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("drain", exp_q0.size() + exp_q1.size(), 32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  int single_vals[4] = '{128, 127, -129, -384};
  int dur, d_plain, d_gap;

  initial begin
    reset     = 1'b1;
    ce        = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    bias      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid0", {31'b0, out_valid0}, 32'd0);
    check_eq("rst_out_valid1", {31'b0, out_valid1}, 32'd0);
    check_eq("rst_in_ready0",  {31'b0, in_ready0},  32'd1);
    check_eq("rst_in_ready1",  {31'b0, in_ready1},  32'd1);
    check_eq("rst_out_data0",  {16'b0, out_data0},  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Eight products of 256, bias 0 -> 8; timing of SUM cycle and slot.
    fill(256);
    send_neuron(16'd0, 16'd0, N_IN, -1, 1'b0, dur);
    @(negedge clk);
    check_eq("t1_sum_out_valid", {31'b0, out_valid0}, 32'd0);
    check_eq("t1_sum_in_ready",  {31'b0, in_ready0},  32'd0);
    @(negedge clk);
    check_eq("t1_out_valid",     {31'b0, out_valid0}, 32'd1);
    check_eq("t1_out_data",      {16'b0, out_data0},  32'd8);
    check_eq("t1_in_ready_back", {31'b0, in_ready0},  32'd1);
    @(negedge clk);
    check_eq("t1_out_valid_1cyc", {31'b0, out_valid0}, 32'd0);
    @(posedge clk); #1;
    wait_drain();

    // Single-product sums: rounding half up in both directions.
    for (int k = 0; k < 4; k++) begin
      fill(0);
      prod_buf[0] = single_vals[k];
      send_neuron(16'd0, 16'd0, N_IN, -1, 1'b0, dur);
    end
    wait_drain();

    // Saturation in both directions (ReLU clamps the negative one in dut1).
    fill((1 << 24) - 1);
    send_neuron(16'd0, 16'd0, N_IN, -1, 1'b0, dur);
    fill(-(1 << 24));
    send_neuron(16'd0, 16'd0, N_IN, -1, 1'b0, dur);
    // Bias alignment, and bias changes after the first product are ignored.
    fill(0);
    send_neuron(16'd1, 16'd1, N_IN, -1, 1'b0, dur);
    send_neuron(16'd3, 16'hff9c, N_IN, -1, 1'b0, dur);
    wait_drain();

    // Back-pressure across two neurons.
    out_ready = 1'b0;
    fill(512);
    send_neuron(16'd0, 16'd0, N_IN, -1, 1'b0, dur);
    fill(-256);
    send_neuron(16'd0, 16'd0, N_IN, -1, 1'b0, dur);
    @(negedge clk);
    @(negedge clk);
    check_eq("bp_in_ready_sum", {31'b0, in_ready0},  32'd0);
    check_eq("bp_held_valid",   {31'b0, out_valid0}, 32'd1);
    check_eq("bp_held_data",    {16'b0, out_data0},  32'd16);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_pop_valid", {31'b0, out_valid0}, 32'd1);
    @(negedge clk);
    check_eq("bp_second_valid", {31'b0, out_valid0}, 32'd1);
    check_eq("bp_second_data",  {16'b0, out_data0},  32'h0000fff8);
    check_eq("bp_in_ready_acc", {31'b0, in_ready0},  32'd1);
    @(posedge clk); #1;
    wait_drain();

    // Reset with a held output and a partial neuron: both are discarded.
    out_ready = 1'b0;
    fill(1000);
    send_neuron(16'd5, 16'd5, N_IN, -1, 1'b0, dur);
    for (int i = 0; i < N_IN; i++) prod_buf[i] = $urandom_range(0, 200000) - 100000;
    send_neuron(16'd7, 16'd7, 5, -1, 1'b0, dur);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    check_eq("rst_mid_out_valid", {31'b0, out_valid0}, 32'd0);
    check_eq("rst_mid_in_ready",  {31'b0, in_ready0},  32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    fill(300);
    send_neuron(16'hfffe, 16'hfffe, N_IN, -1, 1'b0, dur);
    wait_drain();

    // ce low for 3 cycles mid-neuron: same result, 3 cycles later.
    for (int i = 0; i < N_IN; i++) prod_buf[i] = $urandom_range(0, 400000) - 200000;
    send_neuron(16'd9, 16'd9, N_IN, -1, 1'b0, d_plain);
    wait_drain();
    send_neuron(16'd9, 16'd9, N_IN, 4, 1'b0, d_gap);
    wait_drain();
    check_eq("ce_gap_delay", d_gap - d_plain, 32'd3);

    // Random neurons with random consumer back-pressure.
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < N_IN; i++) prod_buf[i] = $urandom_range(0, 1 << 23) - (1 << 22);
      send_neuron(BIAS_W'($urandom_range(0, 1 << 15) - (1 << 14)),
                  BIAS_W'($urandom), N_IN, -1, 1'b1, dur);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
